// File: rtl/hsv_core_commit_ingress.sv
// hsv_core_commit_ingress
//   Commit-side receiver for the execution-unit result channels. It accepts at
//   most one result per cycle, strictly in issue-tag order. A normal result
//   drives the register-file write port. Every accepted result, normal or
//   trapping, pulses retire_valid and bumps retire_count. A trapping result
//   starts a flush: flush_req is broadcast to every unit, and the block waits
//   until every unit has acknowledged before it resumes at tag 0.
//
// Ports
//   clk_core, rst_core        clock, synchronous active-high reset
//   valid_i / ready_o         per-unit handshake (ready_o is combinational)
//   in_tag/in_rd/in_result    per-unit packed payload, unit i at [i*W +: W]
//   in_wb/in_trap             per-unit writeback-enable and trap flag
//   flush_req / flush_ack     flush broadcast and per-unit acknowledge
//   rf_we/rf_waddr/rf_wdata   register-file write port (registered)
//   retire_valid              one-cycle pulse per retired result
//   retire_count              free-running retired-result counter
module hsv_core_commit_ingress #(
   parameter int NUM_UNITS = 3,
   parameter int TAG_W     = 4
) (
   input  logic                      clk_core,
   input  logic                      rst_core,
   input  logic [NUM_UNITS-1:0]      valid_i,
   output logic [NUM_UNITS-1:0]      ready_o,
   input  logic [NUM_UNITS*TAG_W-1:0] in_tag,
   input  logic [NUM_UNITS*5-1:0]    in_rd,
   input  logic [NUM_UNITS*32-1:0]   in_result,
   input  logic [NUM_UNITS-1:0]      in_wb,
   input  logic [NUM_UNITS-1:0]      in_trap,
   output logic                      flush_req,
   input  logic [NUM_UNITS-1:0]      flush_ack,
   output logic                      rf_we,
   output logic [4:0]                rf_waddr,
   output logic [31:0]               rf_wdata,
   output logic                      retire_valid,
   output logic [31:0]               retire_count
);

   localparam int SEL_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

   typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

   state_t               state;
   state_t               state_nxt;
   logic                 flush_first;
   logic [NUM_UNITS-1:0] ack_mask;
   logic [TAG_W-1:0]     expected_tag;

   logic                 sel_hit_p0;
   logic [SEL_W-1:0]     sel_idx_p0;
   logic                 sel_trap_p0;
   logic                 sel_wb_p0;
   logic [4:0]           sel_rd_p0;
   logic [31:0]          sel_result_p0;
   logic                 xfer_p0;
   logic                 ack_all;

   function automatic logic [TAG_W-1:0] tag_inc(input logic [TAG_W-1:0] tag);
      return tag + 1'b1;
   endfunction

   // ---- stage p0: in-order select ----
   // Scan from the top down so the lowest matching index wins.
   always_comb begin
      sel_hit_p0 = 1'b0;
      sel_idx_p0 = '0;
      for (int i = NUM_UNITS - 1; i >= 0; i--) begin
         if (valid_i[i] && (in_tag[i*TAG_W +: TAG_W] == expected_tag)) begin
            sel_hit_p0 = 1'b1;
            sel_idx_p0 = SEL_W'(i);
         end
      end
   end

   always_comb begin
      sel_trap_p0   = in_trap[sel_idx_p0];
      sel_wb_p0     = in_wb[sel_idx_p0];
      sel_rd_p0     = in_rd[int'(sel_idx_p0)*5 +: 5];
      sel_result_p0 = in_result[int'(sel_idx_p0)*32 +: 32];
   end

   // ready_o is ANDed with valid by construction, so a hit is also a transfer.
   assign xfer_p0 = (state == ST_RUN) && !rst_core && sel_hit_p0;

   // Count this cycle's acks too, so the exit does not wait an extra cycle.
   assign ack_all = &(ack_mask | flush_ack);

   // ---- FSM: state register ----
   always_ff @(posedge clk_core) begin
      if (rst_core) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // ---- FSM: next state ----
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN: begin
            if (xfer_p0 && sel_trap_p0) begin
               state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            // Acks seen in the first flush cycle may still be from a previous flush.
            if (!flush_first && ack_all) begin
               state_nxt = ST_RUN;
            end
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      flush_req = (state == ST_FLUSH);
      ready_o   = '0;
      if (xfer_p0) begin
         ready_o = NUM_UNITS'(1) << sel_idx_p0;
      end
   end

   // ---- control registers ----
   always_ff @(posedge clk_core) begin
      if (rst_core) begin
         flush_first  <= 1'b0;
         ack_mask     <= '0;
         expected_tag <= '0;
      end else begin
         flush_first <= (state == ST_RUN) && (state_nxt == ST_FLUSH);
         if (state == ST_FLUSH) begin
            if (state_nxt == ST_RUN) begin
               ack_mask     <= '0;
               expected_tag <= '0;
            end else if (!flush_first) begin
               ack_mask <= ack_mask | flush_ack;
            end
         end else if (xfer_p0 && !sel_trap_p0) begin
            expected_tag <= tag_inc(expected_tag);
         end
      end
   end

   // ---- stage p1: writeback / retire ----
   always_ff @(posedge clk_core) begin
      if (rst_core) begin
         rf_we        <= 1'b0;
         rf_waddr     <= '0;
         rf_wdata     <= '0;
         retire_valid <= 1'b0;
         retire_count <= '0;
      end else begin
         rf_we        <= xfer_p0 && !sel_trap_p0 && sel_wb_p0 && (sel_rd_p0 != 5'd0);
         retire_valid <= xfer_p0;
         if (xfer_p0) begin
            retire_count <= retire_count + 32'd1;
         end
         if (xfer_p0 && !sel_trap_p0) begin
            rf_waddr <= sel_rd_p0;
            rf_wdata <= sel_result_p0;
         end
      end
   end

endmodule

// File: tb/tb_hsv_core_commit_ingress.sv
// tb_hsv_core_commit_ingress
//   Directed bench for hsv_core_commit_ingress (NUM_UNITS=3, TAG_W=4).
//   Inputs change 1 time unit after the rising edge. Outputs are sampled there too.
module tb_hsv_core_commit_ingress;

   localparam int NU = 3;
   localparam int TW = 4;

   logic            clk_core;
   logic            rst_core;
   logic [NU-1:0]   valid_i;
   logic [NU-1:0]   ready_o;
   logic [NU*TW-1:0] in_tag;
   logic [NU*5-1:0] in_rd;
   logic [NU*32-1:0] in_result;
   logic [NU-1:0]   in_wb;
   logic [NU-1:0]   in_trap;
   logic            flush_req;
   logic [NU-1:0]   flush_ack;
   logic            rf_we;
   logic [4:0]      rf_waddr;
   logic [31:0]     rf_wdata;
   logic            retire_valid;
   logic [31:0]     retire_count;

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_cnt;

   hsv_core_commit_ingress #(.NUM_UNITS(NU), .TAG_W(TW)) dut (
      .clk_core(clk_core), .rst_core(rst_core),
      .valid_i(valid_i), .ready_o(ready_o),
      .in_tag(in_tag), .in_rd(in_rd), .in_result(in_result),
      .in_wb(in_wb), .in_trap(in_trap),
      .flush_req(flush_req), .flush_ack(flush_ack),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .retire_valid(retire_valid), .retire_count(retire_count)
   );

   initial clk_core = 1'b0;
   always #5 clk_core = ~clk_core;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_core);
      #1;
   endtask

   task automatic set_unit(input int u, input logic [TW-1:0] tag, input logic [4:0] rd,
                           input logic [31:0] res, input logic wb, input logic trap);
      in_tag[u*TW +: TW]    = tag;
      in_rd[u*5 +: 5]       = rd;
      in_result[u*32 +: 32] = res;
      in_wb[u]              = wb;
      in_trap[u]            = trap;
   endtask

   initial begin
      rst_core  = 1'b1;
      valid_i   = '0;
      in_tag    = '0;
      in_rd     = '0;
      in_result = '0;
      in_wb     = '0;
      in_trap   = '0;
      flush_ack = '0;
      exp_cnt   = 32'd0;

      // Reset: ready stays low even with a matching valid.
      set_unit(0, 4'd0, 5'd5, 32'h1234, 1'b1, 1'b0);
      valid_i = 3'b001;
      #1;
      chk("rst_ready", 32'(ready_o), 32'h0);
      tick();
      chk("rst_flush", 32'(flush_req), 32'h0);
      chk("rst_we", 32'(rf_we), 32'h0);
      chk("rst_rv", 32'(retire_valid), 32'h0);
      chk("rst_cnt", retire_count, 32'h0);
      chk("rst_waddr", 32'(rf_waddr), 32'h0);
      chk("rst_wdata", rf_wdata, 32'h0);

      // 1: single ALU result tag 0.
      rst_core = 1'b0;
      #1;
      chk("t1_ready", 32'(ready_o), 32'h1);
      tick();
      exp_cnt = exp_cnt + 1;
      chk("t1_we", 32'(rf_we), 32'h1);
      chk("t1_waddr", 32'(rf_waddr), 32'd5);
      chk("t1_wdata", rf_wdata, 32'h1234);
      chk("t1_cnt", retire_count, exp_cnt);

      // 2: two units valid together, in-order; unit2 holds a mismatched tag throughout.
      set_unit(0, 4'd1, 5'd6, 32'hAAAA, 1'b1, 1'b0);
      set_unit(1, 4'd2, 5'd7, 32'hBBBB, 1'b1, 1'b0);
      set_unit(2, 4'd9, 5'd8, 32'hCCCC, 1'b1, 1'b0);
      valid_i = 3'b111;
      #1;
      chk("t2_ready_a", 32'(ready_o), 32'h1);
      tick();
      exp_cnt = exp_cnt + 1;
      chk("t2_waddr_a", 32'(rf_waddr), 32'd6);
      chk("t2_wdata_a", rf_wdata, 32'hAAAA);
      chk("t2_cnt_a", retire_count, exp_cnt);
      valid_i = 3'b110;
      #1;
      chk("t2_ready_b", 32'(ready_o), 32'h2);
      tick();
      exp_cnt = exp_cnt + 1;
      chk("t2_waddr_b", 32'(rf_waddr), 32'd7);
      chk("t2_wdata_b", rf_wdata, 32'hBBBB);
      chk("t2_cnt_b", retire_count, exp_cnt);
      valid_i = 3'b100;
      #1;
      chk("t2_ready_none", 32'(ready_o), 32'h0);
      tick();
      chk("t2_idle_rv", 32'(retire_valid), 32'h0);
      chk("t2_idle_we", 32'(rf_we), 32'h0);
      chk("t2_idle_waddr", 32'(rf_waddr), 32'd7);
      chk("t2_idle_wdata", rf_wdata, 32'hBBBB);

      // 3: rd=0 with wb=1 retires without writing.
      set_unit(1, 4'd3, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
      valid_i = 3'b110;
      #1;
      chk("t3_ready", 32'(ready_o), 32'h2);
      tick();
      exp_cnt = exp_cnt + 1;
      chk("t3_we", 32'(rf_we), 32'h0);
      chk("t3_rv", 32'(retire_valid), 32'h1);
      chk("t3_cnt", retire_count, exp_cnt);
      valid_i = 3'b000;

      // 4: tags 4..15, then the tag wraps and a tag-0 result is accepted.
      for (int t = 4; t < 16; t++) begin
         set_unit(0, 4'(t), 5'(t), 32'(t * 32'h101), 1'b1, 1'b0);
         valid_i = 3'b001;
         #1;
         chk("t4_ready", 32'(ready_o), 32'h1);
         tick();
         exp_cnt = exp_cnt + 1;
         chk("t4_wdata", rf_wdata, 32'(t * 32'h101));
      end
      chk("t4_cnt16", retire_count, 32'd16);
      set_unit(0, 4'd0, 5'd1, 32'hC0DE, 1'b1, 1'b0);
      #1;
      chk("t4_wrap_ready", 32'(ready_o), 32'h1);
      tick();
      exp_cnt = exp_cnt + 1;
      chk("t4_wrap_wdata", rf_wdata, 32'hC0DE);
      chk("t4_wrap_cnt", retire_count, exp_cnt);

      // 5: tags 1,2 then trap on tag 3; unit2's ack arrives 3 cycles after the others.
      for (int t = 1; t < 3; t++) begin
         set_unit(0, 4'(t), 5'd2, 32'(t), 1'b1, 1'b0);
         tick();
         exp_cnt = exp_cnt + 1;
      end
      valid_i = 3'b000;
      set_unit(1, 4'd3, 5'd7, 32'hDEAD, 1'b1, 1'b1);
      valid_i = 3'b010;
      #1;
      chk("t5_trap_ready", 32'(ready_o), 32'h2);
      tick();
      exp_cnt = exp_cnt + 1;
      chk("t5_trap_rv", 32'(retire_valid), 32'h1);
      chk("t5_trap_we", 32'(rf_we), 32'h0);
      chk("t5_trap_cnt", retire_count, exp_cnt);
      chk("t5_flush_f1", 32'(flush_req), 32'h1);
      set_unit(0, 4'd0, 5'd3, 32'h0BAD, 1'b1, 1'b0);
      set_unit(1, 4'd4, 5'd4, 32'h0BEE, 1'b1, 1'b0);
      valid_i = 3'b011;
      #1;
      chk("t5_ready_f1", 32'(ready_o), 32'h0);
      tick();
      chk("t5_flush_f2", 32'(flush_req), 32'h1);
      flush_ack = 3'b011;
      tick();
      chk("t5_flush_f3", 32'(flush_req), 32'h1);
      chk("t5_ready_f3", 32'(ready_o), 32'h0);
      tick();
      chk("t5_flush_f4", 32'(flush_req), 32'h1);
      tick();
      chk("t5_flush_f5", 32'(flush_req), 32'h1);
      chk("t5_rv_flush", 32'(retire_valid), 32'h0);
      flush_ack = 3'b111;
      #1;
      chk("t5_flush_f5_held", 32'(flush_req), 32'h1);
      tick();
      chk("t5_flush_drop", 32'(flush_req), 32'h0);
      chk("t5_tag0_ready", 32'(ready_o), 32'h1);

      // 6: trap on the first RUN cycle after flush, stale acks still high.
      set_unit(0, 4'd0, 5'd3, 32'h0BAD, 1'b1, 1'b1);
      #1;
      chk("t6_ready", 32'(ready_o), 32'h1);
      tick();
      exp_cnt = exp_cnt + 1;
      chk("t6_cnt", retire_count, exp_cnt);
      chk("t6_flush_f1", 32'(flush_req), 32'h1);
      chk("t6_we", 32'(rf_we), 32'h0);
      chk("t6_ready_f1", 32'(ready_o), 32'h0);
      tick();
      chk("t6_stale_ignored", 32'(flush_req), 32'h1);
      flush_ack = 3'b000;
      tick();
      chk("t6_flush_f3", 32'(flush_req), 32'h1);
      rst_core = 1'b1;
      tick();
      chk("t6_rst_flush", 32'(flush_req), 32'h0);
      chk("t6_rst_we", 32'(rf_we), 32'h0);
      chk("t6_rst_rv", 32'(retire_valid), 32'h0);
      chk("t6_rst_cnt", retire_count, 32'h0);
      chk("t6_rst_waddr", 32'(rf_waddr), 32'h0);
      chk("t6_rst_wdata", rf_wdata, 32'h0);
      chk("t6_rst_ready", 32'(ready_o), 32'h0);
      rst_core = 1'b0;
      in_trap  = '0;
      #1;
      chk("t6_post_rst_ready", 32'(ready_o), 32'h1);
      valid_i = '0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
